// File: rtl/sp_ram_fifo_ctrl_if.sv
// Stream-side bundle for sp_ram_fifo_ctrl: push/pop handshakes plus fill level.
// Optional almost_full/almost_empty appear when SPF_LEVEL_FLAGS_EN is defined.
interface sp_ram_fifo_ctrl_if #(
  parameter int DW = 4,
  parameter int AW = 4
);
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [AW:0]   level;
`ifdef SPF_LEVEL_FLAGS_EN
  logic          almost_full;
  logic          almost_empty;
`endif

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, level
`ifdef SPF_LEVEL_FLAGS_EN
    , input almost_full, almost_empty
`endif
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, level
`ifdef SPF_LEVEL_FLAGS_EN
    , output almost_full, almost_empty
`endif
  );
endinterface

// File: rtl/sp_ram_fifo_ctrl.sv
// FIFO controller wrapping a single-port sync-read RAM, with a 1-entry head register.
// SPF_LEVEL_FLAGS_EN adds registered almost_full/almost_empty flags.
//
// state   | meaning
// IDLE    | may issue a RAM read or accept a push
// RD_WAIT | read in flight; capture ram_rdata into the head register next edge
module sp_ram_fifo_ctrl #(
  parameter int DW = 4,
  parameter int AW = 4
`ifdef SPF_LEVEL_FLAGS_EN
  , parameter int AF_TH = (1 << AW) - 2,
  parameter int AE_TH = 1
`endif
) (
  input  logic              clk,
  input  logic              rst,
  sp_ram_fifo_ctrl_if.slave bus,
  output logic [AW-1:0]     ram_addr,
  output logic              ram_cs,
  output logic              ram_we,
  output logic              ram_oe,
  output logic              ram_mode_cs,
  output logic [DW-1:0]     ram_wdata,
  input  logic [DW-1:0]     ram_rdata
);
  localparam int DP = 1 << AW;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DP);
  localparam logic [0:0] IDLE    = 1'b0;
  localparam logic [0:0] RD_WAIT = 1'b1;

  logic [0:0]    state;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   mem_cnt;
  logic          out_valid;
  logic [DW-1:0] out_data;

  logic rd_req;
  logic push;
  logic pop;
  logic [AW:0] mem_cnt_nxt;
  logic        out_valid_nxt;

  // Read has priority: a pending read blocks the write port for that cycle.
  assign rd_req      = (state == IDLE) && (mem_cnt != '0) && (!out_valid || bus.out_ready);
  assign bus.in_ready = !rst && (mem_cnt != FULL_CNT) && !rd_req;
  assign push        = bus.in_valid && bus.in_ready;
  assign pop         = out_valid && bus.out_ready;

  assign bus.out_valid = out_valid;
  assign bus.out_data  = out_data;
  assign bus.level     = mem_cnt + {{AW{1'b0}}, out_valid};

  assign ram_mode_cs = 1'b1;
  assign ram_wdata   = bus.in_data;
  assign ram_cs      = rd_req || push;
  assign ram_we      = push;
  assign ram_oe      = rd_req;
  assign ram_addr    = rd_req ? rd_ptr : wr_ptr;

  always_comb begin
    mem_cnt_nxt   = mem_cnt + {{AW{1'b0}}, push} - {{AW{1'b0}}, rd_req};
    out_valid_nxt = out_valid;
    if (state == RD_WAIT)
      out_valid_nxt = 1'b1;
    else if (pop)
      out_valid_nxt = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      mem_cnt   <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      mem_cnt   <= mem_cnt_nxt;
      out_valid <= out_valid_nxt;
      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      if (rd_req) begin
        rd_ptr <= rd_ptr + 1'b1;
        state  <= RD_WAIT;
      end else if (state == RD_WAIT) begin
        out_data <= ram_rdata;
        state    <= IDLE;
      end
    end
  end

`ifdef SPF_LEVEL_FLAGS_EN
  logic [AW:0] level_nxt;
  logic        almost_full;
  logic        almost_empty;

  // Registered from next-state level so the flags line up with level.
  assign level_nxt = mem_cnt_nxt + {{AW{1'b0}}, out_valid_nxt};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
    end else begin
      almost_full  <= (level_nxt >= (AW+1)'(AF_TH));
      almost_empty <= (level_nxt <= (AW+1)'(AE_TH));
    end
  end

  assign bus.almost_full  = almost_full;
  assign bus.almost_empty = almost_empty;
`endif
endmodule

// File: tb/tb_sp_ram_fifo_ctrl.sv
// Self-checking bench for sp_ram_fifo_ctrl with a behavioural sync-read RAM.
module tb_sp_ram_fifo_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;

  sp_ram_fifo_ctrl_if #(.DW(4), .AW(4)) bus ();

  logic [3:0] ram_addr;
  logic       ram_cs;
  logic       ram_we;
  logic       ram_oe;
  logic       ram_mode_cs;
  logic [3:0] ram_wdata;
  logic [3:0] ram_rdata = 4'h0;
  logic [3:0] mem [16];

  int n_chk  = 0;
  int n_fail = 0;
  logic [3:0] exp_q [$];

  sp_ram_fifo_ctrl #(.DW(4), .AW(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .ram_addr    (ram_addr),
    .ram_cs      (ram_cs),
    .ram_we      (ram_we),
    .ram_oe      (ram_oe),
    .ram_mode_cs (ram_mode_cs),
    .ram_wdata   (ram_wdata),
    .ram_rdata   (ram_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_cs && ram_we)
      mem[ram_addr] <= ram_wdata;
    if (ram_cs && ram_oe && !ram_we)
      ram_rdata <= mem[ram_addr];
  end

  typedef struct {
    logic       iv;
    logic [3:0] d;
    logic       ordy;
    logic       e_ir;
    logic       e_cs;
    logic       e_we;
    logic       e_oe;
    logic [3:0] e_addr;
    logic       e_ov;
    logic [3:0] e_od;
    logic [4:0] e_lvl;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic reset_dut();
    @(negedge clk);
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_data = 4'h0;
    bus.out_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
  endtask

  task automatic push_word(input logic [3:0] d);
    bit done = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data = d;
    for (int i = 0; i < 50 && !done; i++) begin
      #1;
      if (bus.in_ready) done = 1'b1;
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    chk("push_accepted", int'(done), 1);
    if (done) exp_q.push_back(d);
  endtask

  task automatic drain();
    bus.out_ready = 1'b1;
    for (int i = 0; i < 200 && exp_q.size() != 0; i++) begin
      #1;
      if (bus.out_valid) chk("drain_data", int'(bus.out_data), int'(exp_q.pop_front()));
      @(negedge clk);
    end
    bus.out_ready = 1'b0;
    chk("drain_complete", exp_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int tx, rx, prev_wr;
    bit saw_wrap;
    logic [3:0] cur_d;

    //          iv  d     or   ir   cs   we   oe   addr  ov   od    lvl
    vecs[0] = '{1'b1, 4'hA, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 4'd0, 1'b0, 4'h0, 5'd0};
    vecs[1] = '{1'b1, 4'hB, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4'd0, 1'b0, 4'h0, 5'd1};
    vecs[2] = '{1'b1, 4'hB, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 4'd1, 1'b0, 4'h0, 5'd0};
    vecs[3] = '{1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 1'b1, 4'hA, 5'd2};
    vecs[4] = '{1'b0, 4'h0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 4'd1, 1'b1, 4'hA, 5'd2};
    vecs[5] = '{1'b0, 4'h0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 4'h0, 5'd0};
    vecs[6] = '{1'b0, 4'h0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 1'b1, 4'hB, 5'd1};
    vecs[7] = '{1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 4'h0, 5'd0};

    bus.in_valid = 1'b0;
    bus.in_data = 4'h0;
    bus.out_ready = 1'b0;

    // Values held while reset is asserted.
    @(negedge clk);
    bus.in_valid = 1'b1;
    #1;
    chk("rst_in_ready", int'(bus.in_ready), 0);
    chk("rst_out_valid", int'(bus.out_valid), 0);
    chk("rst_level", int'(bus.level), 0);
    chk("rst_ram_cs", int'(ram_cs), 0);
    chk("mode_cs", int'(ram_mode_cs), 1);
`ifdef SPF_LEVEL_FLAGS_EN
    chk("rst_almost_full", int'(bus.almost_full), 0);
    chk("rst_almost_empty", int'(bus.almost_empty), 1);
`endif
    bus.in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    // Cycle-by-cycle vectors: latency, read/write collision, pop with bubble.
    for (int v = 0; v < 8; v++) begin
      bus.in_valid = vecs[v].iv;
      bus.in_data = vecs[v].d;
      bus.out_ready = vecs[v].ordy;
      #1;
      chk($sformatf("v%0d_in_ready", v), int'(bus.in_ready), int'(vecs[v].e_ir));
      chk($sformatf("v%0d_ram_cs", v), int'(ram_cs), int'(vecs[v].e_cs));
      chk($sformatf("v%0d_ram_we", v), int'(ram_we), int'(vecs[v].e_we));
      chk($sformatf("v%0d_ram_oe", v), int'(ram_oe), int'(vecs[v].e_oe));
      if (vecs[v].e_cs)
        chk($sformatf("v%0d_ram_addr", v), int'(ram_addr), int'(vecs[v].e_addr));
      if (vecs[v].iv)
        chk($sformatf("v%0d_ram_wdata", v), int'(ram_wdata), int'(vecs[v].d));
      chk($sformatf("v%0d_out_valid", v), int'(bus.out_valid), int'(vecs[v].e_ov));
      if (vecs[v].e_ov)
        chk($sformatf("v%0d_out_data", v), int'(bus.out_data), int'(vecs[v].e_od));
      chk($sformatf("v%0d_level", v), int'(bus.level), int'(vecs[v].e_lvl));
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;

    // Fill to full with the consumer stalled, then drain in order.
    reset_dut();
    for (int i = 0; i < 16; i++) push_word(4'(i));
    repeat (4) @(negedge clk);
    chk("fill16_level", int'(bus.level), 16);
    push_word(4'h5);
    repeat (2) @(negedge clk);
    chk("full_level", int'(bus.level), 17);
    bus.in_valid = 1'b1;
    bus.in_data = 4'h3;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("full_in_ready", int'(bus.in_ready), 0);
      chk("full_ram_we", int'(ram_we), 0);
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    drain();
    repeat (2) @(negedge clk);
    #1;
    chk("drained_level", int'(bus.level), 0);
    chk("drained_out_valid", int'(bus.out_valid), 0);
    @(negedge clk);

    // Random valid/ready over 40 words; pointers wrap twice.
    reset_dut();
    tx = 0;
    rx = 0;
    prev_wr = -1;
    saw_wrap = 1'b0;
    cur_d = 4'($urandom);
    for (int c = 0; c < 3000 && rx < 40; c++) begin
      bus.in_valid = (tx < 40) && ($urandom_range(0, 2) != 0);
      bus.in_data = cur_d;
      bus.out_ready = ($urandom_range(0, 3) != 0);
      #1;
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) chk("wrap_spurious_out", 1, 0);
        else chk("wrap_order", int'(bus.out_data), int'(exp_q.pop_front()));
        rx++;
      end
      if (bus.in_valid && bus.in_ready) begin
        chk("wrap_push_we", int'(ram_we), 1);
        if (prev_wr == 15 && ram_addr == 4'd0) saw_wrap = 1'b1;
        prev_wr = int'(ram_addr);
        exp_q.push_back(cur_d);
        tx++;
        cur_d = 4'($urandom);
      end
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    chk("wrap_words_out", rx, 40);
    chk("ram_addr_wrap", int'(saw_wrap), 1);

    // Reset while a read is in flight with level 5.
    reset_dut();
    for (int i = 1; i <= 7; i++) push_word(4'(i));
    repeat (3) @(negedge clk);
    #1;
    chk("pre_rst_level", int'(bus.level), 7);
    chk("pre_rst_head", int'(bus.out_data), 1);
    bus.out_ready = 1'b1;
    #1;
    chk("pre_rst_read_issue", int'(ram_oe), 1);
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    chk("rd_wait_level", int'(bus.level), 5);
    chk("rd_wait_out_valid", int'(bus.out_valid), 0);
    rst = 1'b1;
    #1;
    chk("midrst_level", int'(bus.level), 0);
    chk("midrst_out_valid", int'(bus.out_valid), 0);
    chk("midrst_in_ready", int'(bus.in_ready), 0);
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    repeat (2) @(negedge clk);
    #1;
    chk("post_rst_no_capture", int'(bus.out_valid), 0);
    chk("post_rst_level", int'(bus.level), 0);
    @(negedge clk);
    push_word(4'h9);
    @(negedge clk);
    #1;
    chk("post_rst_e1_valid", int'(bus.out_valid), 0);
    @(negedge clk);
    #1;
    chk("post_rst_e2_valid", int'(bus.out_valid), 1);
    chk("post_rst_e2_data", int'(bus.out_data), 9);
    chk("post_rst_e2_level", int'(bus.level), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
